wb_shared_slave_arbiter: RTL
============================

Name: wb_shared_slave_arbiter

Overview:
- Shares one Wishbone slave port, such as the UART DPI or Ethernet DPI client port, between two Wishbone masters: master 0 is the CPU data bus, master 1 is the JTAG debug unit.
- Uses round-robin arbitration with bus locking for the duration of `cyc`.
- Has a per-transfer watchdog that terminates a hung slave access with a local error.
- Sits in the SoC between the address decoder and the peripheral slave.

Parameters:
- ADR_WIDTH, 24, address width on all ports.
- TIMEOUT_CYCLES, 255, cycles of unanswered `stb` before a local error; 0 disables the watchdog.
- TIMEOUT_CNT_WIDTH, 8, counter width; must satisfy 2^TIMEOUT_CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rstn_i  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i  in  ADR_WIDTH  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_dat_o  out  32  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  termination to master 0.
- m1_*  same set as m0_* for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_sel_o  out  4  to slave.
- s_adr_o  out  ADR_WIDTH  to slave.
- s_dat_o  out  32  write data to slave.
- s_dat_i  in  32  read data from slave.
- s_ack_i, s_err_i  in  1 each  slave termination.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1. State, owner pointer and counter are registers; slave-side muxing is combinational from state.
- Reset (async assert, sync release):
  - state=IDLE; last_owner=1, so master 0 wins the first tie; counter=0; timeout_o=0.
  - With state IDLE, all s_* control outputs, m*_ack_o, m*_err_o and grant_o are 0.
  - s_adr_o, s_dat_o, s_sel_o, s_we_o and m*_dat_o are 0 while no grant.
- IDLE arbitration:
  - Only m0_cyc_i high: next state GRANT0.
  - Only m1_cyc_i high: next state GRANT1.
  - Both high: grant the master that is not last_owner.
  - The transition updates last_owner.
  - Arbitration latency is one cycle: a request seen in IDLE is forwarded to the slave in the following cycle.
- GRANTx:
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o equal master x inputs.
  - mx_ack_o=s_ack_i and mx_err_o=s_err_i, both combinational, zero added latency; simultaneous ack and err pass through unchanged.
  - mx_dat_o=s_dat_i.
  - The other master sees ack=0, err=0, dat=0, and its requests wait.
  - When mx_cyc_i drops, next state is IDLE. There is always one dead cycle between owners, so no direct handover.
- Watchdog (GRANTx only, TIMEOUT_CYCLES>0):
  - Counter clears on entry to GRANTx, on any s_ack_i or s_err_i, and while mx_stb_i is low.
  - Otherwise the counter increments each cycle.
  - When counter==TIMEOUT_CYCLES-1 with stb high and no slave termination, the current cycle is the last. In the next cycle: state=DRAINx, mx_err_o=1 for exactly one cycle, timeout_o=1 for one cycle, s_cyc_o=s_stb_o=0.
- DRAINx:
  - Slave outputs are deasserted; grant_o stays on master x.
  - No ack or err is given for further strobes from master x.
  - A late s_ack_i/s_err_i is ignored.
  - Leaves to IDLE when mx_cyc_i is low.
- Owner drops cyc mid-transfer (stb high, no ack): the slave cycle is abandoned; IDLE next cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately (async); the arbitration pointer returns to favour master 0.

Test Plan:
- Single master 0 write, adr=0x000010, dat=0xA5A5A5A5, slave acks 2 cycles after stb → s_* mirrors m0 from the cycle after request; m0_ack_o for 1 cycle; grant_o=01, then 00.
- Both cyc rise in the same cycle after reset, 3 back-to-back rounds → grant order 0,1,0; exactly 1 idle cycle between owners; losing master's ack/err never asserted.
- Master 1 read while master 0 asserts cyc mid-transfer, slave returns 0x12345678 → m1_dat_o=0x12345678 with m1_ack_o; master 0 is forwarded only after m1_cyc_i drops plus one IDLE cycle.
- Slave never acks, TIMEOUT_CYCLES=8 → m0_err_o and timeout_o high in the 9th cycle after stb first seen in GRANT0; s_cyc_o low that cycle; a late s_ack_i is ignored; IDLE after m0_cyc_i drops.
- Slave asserts s_err_i and s_ack_i together → both are forwarded to the owner in the same cycle; no timeout.
- wb_rstn_i pulled low for 1 cycle during a granted stall → grant_o=00, s_cyc_o=0 and no ack/err within the same cycle; after release, a simultaneous request from both masters grants master 0.

Source files
------------

// File: rtl/wb_shared_slave_arbiter.sv
// Shares one Wishbone slave between two masters. Round-robin arbitration, and the bus stays locked while cyc is held.
// A watchdog ends any strobe the slave leaves unanswered with a local error.
module wb_shared_slave_arbiter #(
  parameter int ADR_WIDTH         = 24,
  parameter int TIMEOUT_CYCLES    = 255,
  parameter int TIMEOUT_CNT_WIDTH = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rstn_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1} state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TO_LAST =
    TIMEOUT_CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                       state_q, state_d;
  logic                         last_owner_q, last_owner_d;
  logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                         timeout_q, timeout_d;

  logic                 own1, granted;
  logic                 sel_cyc, sel_stb, sel_we;
  logic [3:0]           sel_sel;
  logic [ADR_WIDTH-1:0] sel_adr;
  logic [31:0]          sel_dat;

  assign own1    = (state_q == GRANT1) || (state_q == DRAIN1);
  assign granted = (state_q == GRANT0) || (state_q == GRANT1);
  assign sel_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign sel_stb = own1 ? m1_stb_i : m0_stb_i;
  assign sel_we  = own1 ? m1_we_i  : m0_we_i;
  assign sel_sel = own1 ? m1_sel_i : m0_sel_i;
  assign sel_adr = own1 ? m1_adr_i : m0_adr_i;
  assign sel_dat = own1 ? m1_dat_i : m0_dat_i;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Counter defaults to zero, which covers entry, slave termination and stb low.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
          state_d      = GRANT0;
          last_owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = GRANT1;
          last_owner_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!sel_cyc) begin
          state_d = IDLE;
        end else if (sel_stb && !s_ack_i && !s_err_i) begin
          if (WD_EN && (cnt_q == TO_LAST)) begin
            state_d   = own1 ? DRAIN1 : DRAIN0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN0, DRAIN1: begin
        if (!sel_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_cyc_o = granted & sel_cyc;
  assign s_stb_o = granted & sel_stb;
  assign s_we_o  = granted & sel_we;
  assign s_sel_o = granted ? sel_sel : '0;
  assign s_adr_o = granted ? sel_adr : '0;
  assign s_dat_o = granted ? sel_dat : '0;

  // The local error is the first drain cycle only; later slave terminations are dropped.
  assign m0_ack_o = (state_q == GRANT0) & s_ack_i;
  assign m1_ack_o = (state_q == GRANT1) & s_ack_i;
  assign m0_err_o = ((state_q == GRANT0) & s_err_i) | ((state_q == DRAIN0) & timeout_q);
  assign m1_err_o = ((state_q == GRANT1) & s_err_i) | ((state_q == DRAIN1) & timeout_q);
  assign m0_dat_o = (state_q == GRANT0) ? s_dat_i : '0;
  assign m1_dat_o = (state_q == GRANT1) ? s_dat_i : '0;

  assign grant_o   = {own1, (state_q == GRANT0) || (state_q == DRAIN0)};
  assign timeout_o = timeout_q;

endmodule
